// File: rtl/memtest_pattern_gen_if.sv
// Seed/size input streams and pattern/status output streams of the memtest data generator.
interface memtest_pattern_gen_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned SIZE_W = 32
);
    logic              asi_seed_valid;
    logic [DATA_W-1:0] asi_seed_data;
    logic              asi_size_valid;
    logic [SIZE_W-1:0] asi_size_data;
    logic              aso_data_ready;
    logic              aso_data_valid;
    logic [DATA_W-1:0] aso_data_data;
    logic              aso_data_startofpacket;
    logic              aso_data_endofpacket;
    logic [3:0]        aso_pktstatus_data;

    // Controller / downstream side
    modport master (
        output asi_seed_valid, asi_seed_data, asi_size_valid, asi_size_data, aso_data_ready,
        input  aso_data_valid, aso_data_data, aso_data_startofpacket, aso_data_endofpacket,
               aso_pktstatus_data
    );

    // Generator side
    modport slave (
        input  asi_seed_valid, asi_seed_data, asi_size_valid, asi_size_data, aso_data_ready,
        output aso_data_valid, aso_data_data, aso_data_startofpacket, aso_data_endofpacket,
               aso_pktstatus_data
    );
endinterface

// File: rtl/memtest_pattern_gen.sv
// Memtest pattern generator: emits SIZE-beat packets of parallel xorshift32 lanes seeded
// from the seed stream, with a sticky packet status word.
module memtest_pattern_gen #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned SIZE_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    memtest_pattern_gen_if.slave  bus
);
    localparam int unsigned LANES  = DATA_W / 32;
    localparam int unsigned LANE_W = 32;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] cnt_q, cnt_d;
    logic [SIZE_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] lanes_q, lanes_d;
    logic              valid_q, valid_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              const_q, const_d;
    logic              accept;

    function automatic logic [LANE_W-1:0] xs32(input logic [LANE_W-1:0] x);
        logic [LANE_W-1:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = s;
        for (int k = 0; k < int'(LANES); k++) begin
            r[LANE_W*k +: LANE_W] = xs32(s[LANE_W*k +: LANE_W]);
        end
        return r;
    endfunction

    assign accept = valid_q & bus.aso_data_ready;

    // Next-state, counters, lanes and registered output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        lanes_d = lanes_q;
        done_d  = done_q;
        err_d   = err_q;
        const_d = const_q;

        unique case (state_q)
            IDLE: begin
                if (bus.asi_size_valid) begin
                    if (bus.asi_size_data != '0) begin
                        state_d = RUN;
                        len_d   = bus.asi_size_data;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        const_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.asi_seed_valid) const_d = 1'b1;
                if (bus.asi_size_valid) err_d = 1'b1;
                if (accept) begin
                    lanes_d = advance(lanes_q);
                    if (eop_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + SIZE_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A seed write always wins over lane advance
        if (bus.asi_seed_valid) lanes_d = bus.asi_seed_data;

        busy_d  = (state_d == RUN);
        valid_d = (state_d == RUN);
        sop_d   = (state_d == RUN) && (cnt_d == '0);
        eop_d   = (state_d == RUN) && (cnt_d == len_d - SIZE_W'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            lanes_q <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            const_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            lanes_q <= lanes_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            const_q <= const_d;
        end
    end

    assign bus.aso_data_valid         = valid_q;
    assign bus.aso_data_data          = lanes_q;
    assign bus.aso_data_startofpacket = sop_q;
    assign bus.aso_data_endofpacket   = eop_q;
    assign bus.aso_pktstatus_data     = {const_q, err_q, done_q, busy_q};

endmodule

// File: tb/tb_memtest_pattern_gen.sv
// Directed bench for memtest_pattern_gen with hand-computed xorshift32 expectations.
module tb_memtest_pattern_gen;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned SIZE_W = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   acc;
    logic [31:0] exp_lane [4];

    memtest_pattern_gen_if #(.DATA_W(DATA_W), .SIZE_W(SIZE_W)) bus ();

    memtest_pattern_gen #(.DATA_W(DATA_W), .SIZE_W(SIZE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [127:0] d, input logic s, input logic e);
        chk({tag, "_valid"}, 128'(bus.aso_data_valid), 128'(1));
        chk({tag, "_data"}, bus.aso_data_data, d);
        chk({tag, "_sop"}, 128'(bus.aso_data_startofpacket), 128'(s));
        chk({tag, "_eop"}, 128'(bus.aso_data_endofpacket), 128'(e));
    endtask

    task automatic start(input logic [127:0] seed, input logic [31:0] size);
        bus.asi_seed_valid = 1'b1;
        bus.asi_seed_data  = seed;
        bus.asi_size_valid = 1'b1;
        bus.asi_size_data  = size;
        step();
        bus.asi_seed_valid = 1'b0;
        bus.asi_size_valid = 1'b0;
    endtask

    initial begin
        exp_lane[0] = 32'h0000_0001;
        exp_lane[1] = 32'h0004_2021;
        exp_lane[2] = 32'h0408_0601;
        exp_lane[3] = 32'h9DCC_A8C5;

        bus.asi_seed_valid = 1'b0;
        bus.asi_seed_data  = '0;
        bus.asi_size_valid = 1'b0;
        bus.asi_size_data  = '0;
        bus.aso_data_ready = 1'b1;
        reset_n = 1'b0;
        #23;
        chk("rst_valid", 128'(bus.aso_data_valid), 128'(0));
        chk("rst_data", bus.aso_data_data, 128'(0));
        chk("rst_status", 128'(bus.aso_pktstatus_data), 128'(0));
        reset_n = 1'b1;
        step();

        // 1: size=3 from seed of ones
        start({4{32'h1}}, 32'd3);
        beat("t1_b0", {4{exp_lane[0]}}, 1'b1, 1'b0);
        chk("t1_busy", 128'(bus.aso_pktstatus_data), 128'(4'b0001));
        step();
        beat("t1_b1", {4{exp_lane[1]}}, 1'b0, 1'b0);
        step();
        beat("t1_b2", {4{exp_lane[2]}}, 1'b0, 1'b1);
        step();
        chk("t1_end_valid", 128'(bus.aso_data_valid), 128'(0));
        chk("t1_end_status", 128'(bus.aso_pktstatus_data), 128'(4'b0010));

        // 2: single-beat packet
        start({4{32'hDEAD_BEEF}}, 32'd1);
        beat("t2_b0", {4{32'hDEAD_BEEF}}, 1'b1, 1'b1);
        step();
        chk("t2_end_valid", 128'(bus.aso_data_valid), 128'(0));
        chk("t2_end_status", 128'(bus.aso_pktstatus_data), 128'(4'b0010));

        // 3: size=4 with ready pattern 1,0,0,1,0,0,...
        start({4{32'h1}}, 32'd4);
        acc = 0;
        for (int i = 0; i < 30 && acc < 4; i++) begin
            bus.aso_data_ready = (i % 3 == 0);
            beat("t3_beat", {4{exp_lane[acc]}}, acc == 0, acc == 3);
            if (bus.aso_data_ready) acc++;
            step();
        end
        bus.aso_data_ready = 1'b1;
        chk("t3_accepted", 128'(acc), 128'(4));
        chk("t3_end_valid", 128'(bus.aso_data_valid), 128'(0));
        chk("t3_end_status", 128'(bus.aso_pktstatus_data), 128'(4'b0010));

        // 4: constant mode, seed held for the whole packet
        bus.asi_seed_valid = 1'b1;
        bus.asi_seed_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        bus.asi_size_valid = 1'b1;
        bus.asi_size_data  = 32'd5;
        step();
        bus.asi_size_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat("t4_beat", {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                 i == 0, i == 4);
            step();
        end
        chk("t4_end_valid", 128'(bus.aso_data_valid), 128'(0));
        chk("t4_end_status", 128'(bus.aso_pktstatus_data), 128'(4'b1010));
        bus.asi_seed_valid = 1'b0;

        // 5: zero size rejected, then a start request mid-packet is ignored
        bus.asi_size_valid = 1'b1;
        bus.asi_size_data  = 32'd0;
        step();
        bus.asi_size_valid = 1'b0;
        chk("t5_zero_valid", 128'(bus.aso_data_valid), 128'(0));
        chk("t5_zero_status", 128'(bus.aso_pktstatus_data), 128'(4'b1110));
        start({4{32'h1}}, 32'd4);
        beat("t5_b0", {4{exp_lane[0]}}, 1'b1, 1'b0);
        chk("t5_start_status", 128'(bus.aso_pktstatus_data), 128'(4'b0001));
        step();
        beat("t5_b1", {4{exp_lane[1]}}, 1'b0, 1'b0);
        step();
        beat("t5_b2", {4{exp_lane[2]}}, 1'b0, 1'b0);
        bus.asi_size_valid = 1'b1;
        bus.asi_size_data  = 32'd8;
        step();
        bus.asi_size_valid = 1'b0;
        beat("t5_b3", {4{exp_lane[3]}}, 1'b0, 1'b1);
        chk("t5_err_status", 128'(bus.aso_pktstatus_data), 128'(4'b0101));
        step();
        chk("t5_end_valid", 128'(bus.aso_data_valid), 128'(0));
        chk("t5_end_status", 128'(bus.aso_pktstatus_data), 128'(4'b0110));
        step();
        step();
        chk("t5_no_extra", 128'(bus.aso_data_valid), 128'(0));

        // 6: asynchronous reset mid-packet, then a clean restart
        start({4{32'hCAFE_F00D}}, 32'd10);
        beat("t6_b0", {4{32'hCAFE_F00D}}, 1'b1, 1'b0);
        step();
        step();
        chk("t6_b2_valid", 128'(bus.aso_data_valid), 128'(1));
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 128'(bus.aso_data_valid), 128'(0));
        chk("t6_rst_eop", 128'(bus.aso_data_endofpacket), 128'(0));
        chk("t6_rst_status", 128'(bus.aso_pktstatus_data), 128'(0));
        chk("t6_rst_data", bus.aso_data_data, 128'(0));
        #2;
        reset_n = 1'b1;
        step();
        chk("t6_idle_valid", 128'(bus.aso_data_valid), 128'(0));
        start({4{32'h1}}, 32'd2);
        beat("t6_r0", {4{exp_lane[0]}}, 1'b1, 1'b0);
        step();
        beat("t6_r1", {4{exp_lane[1]}}, 1'b0, 1'b1);
        step();
        chk("t6_end_status", 128'(bus.aso_pktstatus_data), 128'(4'b0010));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
